open_drain_bank: RTL

//  Parametrised bank of CHANNELS open-drain lines (I2C-style SCL/SDA, interrupt, wired-AND).
//  Per channel: registered drive, input synchroniser, glitch filter, edge pulses, external-hold detection.

---
 rtl/open_drain_bank.sv | 105 ++++++++++
 1 files changed

// File: rtl/open_drain_bank.sv
// Bank of open-drain lines: registered low-drive, input synchroniser, glitch filter,
// edge pulses and detection of a line held low by another device after release.
module open_drain_bank #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_DEPTH = 3
) (
  input  logic                I_CLK,
  input  logic                I_NRESET,
  input  logic [CHANNELS-1:0] I_RELEASE,
  input  logic [CHANNELS-1:0] I_ARB_CLR,
  inout  wire  [CHANNELS-1:0] IO_LINE,
  output logic [CHANNELS-1:0] O_LEVEL,
  output logic [CHANNELS-1:0] O_FALL,
  output logic [CHANNELS-1:0] O_RISE,
  output logic [CHANNELS-1:0] O_HELD,
  output logic [CHANNELS-1:0] O_ARB_LOST
);

  localparam int unsigned CNT_W  = $clog2(FILTER_DEPTH + 1);
  localparam int unsigned SETTLE = SYNC_STAGES + FILTER_DEPTH + 1;
  localparam int unsigned SET_W  = $clog2(SETTLE + 1);

  logic [CHANNELS-1:0] drv_q;

  // Reset releases every line at once, even mid-transfer.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) drv_q <= '1;
    else           drv_q <= I_RELEASE;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       filt_q, filt_d;
    logic [SET_W-1:0]       settle_q, settle_d;
    logic                   level_q, level_d;
    logic                   fall_q, fall_d;
    logic                   rise_q, rise_d;
    logic                   arb_q, arb_d;
    logic                   s;
    logic                   settled;
    logic                   held;

    assign IO_LINE[i] = drv_q[i] ? 1'bz : 1'b0;

    assign s       = sync_q[SYNC_STAGES-1];
    assign settled = (settle_q == SET_W'(SETTLE));
    assign held    = drv_q[i] & settled & ~level_q;

    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], IO_LINE[i]};
      filt_d   = '0;
      level_d  = level_q;
      fall_d   = 1'b0;
      rise_d   = 1'b0;
      settle_d = '0;
      arb_d    = arb_q;

      // A new level is accepted only after FILTER_DEPTH consecutive differing samples.
      if (s != level_q) begin
        if (filt_q == CNT_W'(FILTER_DEPTH - 1)) begin
          level_d = s;
          fall_d  = ~s;
          rise_d  = s;
        end else begin
          filt_d = filt_q + CNT_W'(1);
        end
      end

      if (drv_q[i]) begin
        settle_d = settled ? settle_q : settle_q + SET_W'(1);
      end

      if (held)              arb_d = 1'b1;
      else if (I_ARB_CLR[i]) arb_d = 1'b0;
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
        sync_q   <= '1;
        filt_q   <= '0;
        settle_q <= '0;
        level_q  <= 1'b1;
        fall_q   <= 1'b0;
        rise_q   <= 1'b0;
        arb_q    <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        filt_q   <= filt_d;
        settle_q <= settle_d;
        level_q  <= level_d;
        fall_q   <= fall_d;
        rise_q   <= rise_d;
        arb_q    <= arb_d;
      end
    end

    assign O_LEVEL[i]    = level_q;
    assign O_FALL[i]     = fall_q;
    assign O_RISE[i]     = rise_q;
    assign O_HELD[i]     = held;
    assign O_ARB_LOST[i] = arb_q;
  end

endmodule
